exc_vector_sequencer: RTL and testbench
=======================================

Name: exc_vector_sequencer

Overview:
- Parametrised successor to the fixed memory-address selector of the multicycle datapath.
- Selects the memory address: PC or ALU result in normal operation; exception vector addresses (VEC_BASE+cause) during exception entry.
- Sequences exception entry: prioritises causes, saves EPC, waits for memory latency, captures the vector byte and loads it into PC.
- Sits between the control unit, PC/EPC registers and the memory address port.

Parameters:
- DATA_W, 32, width of addresses, PC, EPC and ALU result.
- NUM_CAUSE, 3, number of exception causes (bit0 = invalid opcode, bit1 = overflow, bit2 = divide-by-zero).
- VEC_BASE, 253, vector address of cause 0; cause i uses VEC_BASE+i.
- MEM_LAT, 1, cycles from address presented to mem_rdata valid (1..15).
- EPC_OFFSET, 4, value subtracted from pc_in when forming EPC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- addr_sel  in  1  normal-mode select: 0 = pc_in, 1 = alu_in.
- pc_in  in  DATA_W  current PC.
- alu_in  in  DATA_W  ALU result / computed address.
- exc_req  in  NUM_CAUSE  exception request, one bit per cause, level-sampled.
- mem_rdata  in  8  memory read byte.
- mem_addr  out  DATA_W  memory address.
- busy  out  1  high while sequencing; control unit stalls.
- pc_load  out  1  one-cycle strobe: write pc_new into PC.
- pc_new  out  DATA_W  zero-extended vector byte.
- epc_load  out  1  one-cycle strobe: write epc_out into EPC.
- epc_out  out  DATA_W  pc_in - EPC_OFFSET, captured at entry.
- cause_out  out  $clog2(NUM_CAUSE)  index of the cause being or last serviced.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; busy=0, pc_load=0, epc_load=0, pc_new=0, epc_out=0, cause_out=0, wait counter=0. Reset wins over every other event, including mid-sequence (sequence aborted, no pc_load).
- mem_addr is combinational:
  - IDLE: addr_sel ? alu_in : pc_in.
  - Any other state: VEC_BASE + cause_out, in DATA_W bits, zero-extended.
- States:
  - IDLE: if exc_req != 0 at a clk edge, go to VEC. In that same edge: cause_out <= lowest set bit index (bit0 has highest priority); epc_out <= pc_in - EPC_OFFSET, modulo 2^DATA_W, so pc_in=0 gives 0xFFFFFFFC; epc_load <= 1; busy <= 1; counter <= MEM_LAT-1.
  - VEC: epc_load=0. While counter != 0, decrement. At counter==0, go to LOAD.
  - LOAD: pc_new <= {zeros, mem_rdata}; pc_load <= 1; busy <= 0; go to IDLE.
- pc_load and epc_load are each high for exactly one cycle.
- Latency: exc_req sampled at edge N gives epc_load high in N..N+1 and pc_load high after edge N+MEM_LAT+1. busy is high for MEM_LAT+1 cycles.
- exc_req while busy or in LOAD: ignored in the base build. The request is re-sampled in IDLE on the cycle after pc_load, so a still-asserted level re-triggers.
- Multiple simultaneous bits: only the highest-priority cause is serviced; the others are dropped (base build).
- cause_out holds its value after the sequence until the next entry.
- pc_new holds its value until the next LOAD.

Optional Feature:
- Macro: EXC_PENDING_EN.
- Defined:
  - A NUM_CAUSE-bit pending register ORs in every exc_req bit not being serviced, including bits arriving while busy.
  - On return to IDLE, pending != 0 starts a new entry immediately (same priority rule, EPC from current pc_in), and the serviced bit is cleared.
  - Reset clears pending.
- Undefined: no pending register; behaviour is as in the base build.

Test Plan:
- Reset then addr_sel=0, pc_in=0x40, alu_in=0x1234 -> mem_addr=0x40; addr_sel=1 -> mem_addr=0x1234; busy=0, all strobes 0.
- exc_req=3'b010, pc_in=0x100, MEM_LAT=1 -> cause_out=1, epc_out=0xFC with one-cycle epc_load; mem_addr=254; mem_rdata=0x7A -> pc_new=0x7A, pc_load one cycle, busy high exactly 2 cycles.
- exc_req=3'b110 -> cause_out=1, mem_addr=254; cause 2 dropped (base build) / serviced next with mem_addr=255 (EXC_PENDING_EN).
- MEM_LAT=3, exc_req=3'b100 -> mem_addr=255 for 4 cycles, pc_load on the 4th edge after entry; mem_rdata changes before the final cycle are ignored.
- reset asserted in VEC -> next cycle busy=0, no pc_load, mem_addr back to mux value, cause_out=0.
- pc_in=0 with exc_req=3'b001 -> epc_out=0xFFFFFFFC, mem_addr=253.

Source files
------------

// File: rtl/exc_vector_sequencer.sv
// rtl/exc_vector_sequencer.sv - memory address mux and exception-vector entry sequencer (optional EXC_PENDING_EN)
module exc_vector_sequencer #(
    parameter int DATA_W     = 32,
    parameter int NUM_CAUSE  = 3,
    parameter int VEC_BASE   = 253,
    parameter int MEM_LAT    = 1,
    parameter int EPC_OFFSET = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         addr_sel,
    input  logic [DATA_W-1:0]            pc_in,
    input  logic [DATA_W-1:0]            alu_in,
    input  logic [NUM_CAUSE-1:0]         exc_req,
    input  logic [7:0]                   mem_rdata,
    output logic [DATA_W-1:0]            mem_addr,
    output logic                         busy,
    output logic                         pc_load,
    output logic [DATA_W-1:0]            pc_new,
    output logic                         epc_load,
    output logic [DATA_W-1:0]            epc_out,
    output logic [$clog2(NUM_CAUSE)-1:0] cause_out
);

    localparam int CAUSE_W = $clog2(NUM_CAUSE);
    localparam logic [DATA_W-1:0] VEC_BASE_W   = DATA_W'(VEC_BASE);
    localparam logic [DATA_W-1:0] EPC_OFFSET_W = DATA_W'(EPC_OFFSET);
    localparam logic [3:0]        LAT_M1       = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_VEC, S_LOAD} state_t;

    state_t               r_state, w_state;
    logic                 r_busy, w_busy;
    logic                 r_pc_load, w_pc_load;
    logic                 r_epc_load, w_epc_load;
    logic [DATA_W-1:0]    r_pc_new, w_pc_new;
    logic [DATA_W-1:0]    r_epc_out, w_epc_out;
    logic [CAUSE_W-1:0]   r_cause, w_cause;
    logic [3:0]           r_cnt, w_cnt;
    logic [NUM_CAUSE-1:0] w_src;
    logic [CAUSE_W-1:0]   w_pick;
`ifdef EXC_PENDING_EN
    logic [NUM_CAUSE-1:0] r_pending, w_pending;

    assign w_src = exc_req | r_pending;
`else
    assign w_src = exc_req;
`endif

    // Descending scan so the lowest set index is the final assignment.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--) begin
            if (w_src[i]) w_pick = CAUSE_W'(i);
        end
    end

    always_comb begin
        w_state    = r_state;
        w_busy     = r_busy;
        w_pc_load  = 1'b0;
        w_epc_load = 1'b0;
        w_pc_new   = r_pc_new;
        w_epc_out  = r_epc_out;
        w_cause    = r_cause;
        w_cnt      = r_cnt;
`ifdef EXC_PENDING_EN
        w_pending  = r_pending;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_src != '0) begin
                    w_state    = S_VEC;
                    w_cause    = w_pick;
                    w_epc_out  = pc_in - EPC_OFFSET_W;
                    w_epc_load = 1'b1;
                    w_busy     = 1'b1;
                    w_cnt      = LAT_M1;
`ifdef EXC_PENDING_EN
                    w_pending  = w_src & ~(NUM_CAUSE'(1) << w_pick);
`endif
                end
            end
            S_VEC: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_state = S_LOAD;
                end
`ifdef EXC_PENDING_EN
                w_pending = r_pending | (exc_req & ~(NUM_CAUSE'(1) << r_cause));
`endif
            end
            S_LOAD: begin
                w_pc_new  = {{(DATA_W-8){1'b0}}, mem_rdata};
                w_pc_load = 1'b1;
                w_busy    = 1'b0;
                w_state   = S_IDLE;
`ifdef EXC_PENDING_EN
                w_pending = r_pending | (exc_req & ~(NUM_CAUSE'(1) << r_cause));
`endif
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc_load  <= 1'b0;
            r_epc_load <= 1'b0;
            r_pc_new   <= '0;
            r_epc_out  <= '0;
            r_cause    <= '0;
            r_cnt      <= 4'd0;
`ifdef EXC_PENDING_EN
            r_pending  <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_busy     <= w_busy;
            r_pc_load  <= w_pc_load;
            r_epc_load <= w_epc_load;
            r_pc_new   <= w_pc_new;
            r_epc_out  <= w_epc_out;
            r_cause    <= w_cause;
            r_cnt      <= w_cnt;
`ifdef EXC_PENDING_EN
            r_pending  <= w_pending;
`endif
        end
    end

    assign mem_addr  = (r_state == S_IDLE) ? (addr_sel ? alu_in : pc_in)
                                           : VEC_BASE_W + {{(DATA_W-CAUSE_W){1'b0}}, r_cause};
    assign busy      = r_busy;
    assign pc_load   = r_pc_load;
    assign pc_new    = r_pc_new;
    assign epc_load  = r_epc_load;
    assign epc_out   = r_epc_out;
    assign cause_out = r_cause;

endmodule

// File: tb/tb_exc_vector_sequencer.sv
// tb/tb_exc_vector_sequencer.sv - directed self-checking bench, MEM_LAT=1 and MEM_LAT=3 instances
module tb_exc_vector_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        addr_sel;
    logic [31:0] pc_in, alu_in;
    logic [2:0]  exc_req1, exc_req3;
    logic [7:0]  mem_rdata;

    logic [31:0] mem_addr1, pc_new1, epc_out1;
    logic        busy1, pc_load1, epc_load1;
    logic [1:0]  cause1;
    logic [31:0] mem_addr3, pc_new3, epc_out3;
    logic        busy3, pc_load3, epc_load3;
    logic [1:0]  cause3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_vector_sequencer #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .addr_sel(addr_sel), .pc_in(pc_in), .alu_in(alu_in),
        .exc_req(exc_req1), .mem_rdata(mem_rdata), .mem_addr(mem_addr1), .busy(busy1),
        .pc_load(pc_load1), .pc_new(pc_new1), .epc_load(epc_load1), .epc_out(epc_out1),
        .cause_out(cause1)
    );

    exc_vector_sequencer #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .addr_sel(addr_sel), .pc_in(pc_in), .alu_in(alu_in),
        .exc_req(exc_req3), .mem_rdata(mem_rdata), .mem_addr(mem_addr3), .busy(busy3),
        .pc_load(pc_load3), .pc_new(pc_new3), .epc_load(epc_load3), .epc_out(epc_out3),
        .cause_out(cause3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; addr_sel = 1'b0; pc_in = 32'h0; alu_in = 32'h0;
        exc_req1 = 3'b000; exc_req3 = 3'b000; mem_rdata = 8'h00;
        step(); step();
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_pc_load", {31'b0, pc_load1}, 32'd0);
        chk("rst_epc_load", {31'b0, epc_load1}, 32'd0);
        chk("rst_pc_new", pc_new1, 32'd0);
        chk("rst_epc_out", epc_out1, 32'd0);
        chk("rst_cause", {30'b0, cause1}, 32'd0);
        reset = 1'b1;

        // normal address mux
        pc_in = 32'h40; alu_in = 32'h1234; addr_sel = 1'b0; #1;
        chk("mux_pc", mem_addr1, 32'h40);
        addr_sel = 1'b1; #1;
        chk("mux_alu", mem_addr1, 32'h1234);
        step();
        chk("idle_busy", {31'b0, busy1}, 32'd0);

        // single cause, MEM_LAT=1
        addr_sel = 1'b0; pc_in = 32'h100; exc_req1 = 3'b010;
        step();
        chk("e1_epc_load", {31'b0, epc_load1}, 32'd1);
        chk("e1_epc_out", epc_out1, 32'hFC);
        chk("e1_cause", {30'b0, cause1}, 32'd1);
        chk("e1_busy0", {31'b0, busy1}, 32'd1);
        chk("e1_addr0", mem_addr1, 32'd254);
        exc_req1 = 3'b000; mem_rdata = 8'h7A;
        step();
        chk("e1_epc_drop", {31'b0, epc_load1}, 32'd0);
        chk("e1_busy1", {31'b0, busy1}, 32'd1);
        chk("e1_no_pcl", {31'b0, pc_load1}, 32'd0);
        chk("e1_addr1", mem_addr1, 32'd254);
        step();
        chk("e1_pc_load", {31'b0, pc_load1}, 32'd1);
        chk("e1_pc_new", pc_new1, 32'h7A);
        chk("e1_busy_end", {31'b0, busy1}, 32'd0);
        chk("e1_addr_back", mem_addr1, 32'h100);
        step();
        chk("e1_pcl_once", {31'b0, pc_load1}, 32'd0);

        // simultaneous causes: 1 wins, 2 dropped
        exc_req1 = 3'b110;
        step();
        chk("e2_cause", {30'b0, cause1}, 32'd1);
        chk("e2_addr", mem_addr1, 32'd254);
        exc_req1 = 3'b000;
        step(); step();
        chk("e2_pc_load", {31'b0, pc_load1}, 32'd1);
        step();
        chk("e2_dropped_busy", {31'b0, busy1}, 32'd0);
        chk("e2_dropped_epc", {31'b0, epc_load1}, 32'd0);
        chk("e2_cause_hold", {30'b0, cause1}, 32'd1);

        // MEM_LAT=3, early mem_rdata values ignored
        pc_in = 32'h200; exc_req3 = 3'b100; mem_rdata = 8'h11;
        step();
        chk("e3_addr0", mem_addr3, 32'd255);
        chk("e3_cause", {30'b0, cause3}, 32'd2);
        chk("e3_epc_out", epc_out3, 32'h1FC);
        exc_req3 = 3'b000;
        step();
        chk("e3_addr1", mem_addr3, 32'd255);
        mem_rdata = 8'h22;
        step();
        chk("e3_addr2", mem_addr3, 32'd255);
        chk("e3_no_pcl", {31'b0, pc_load3}, 32'd0);
        mem_rdata = 8'h33;
        step();
        chk("e3_addr3", mem_addr3, 32'd255);
        chk("e3_busy3", {31'b0, busy3}, 32'd1);
        mem_rdata = 8'h5C;
        step();
        chk("e3_pc_load", {31'b0, pc_load3}, 32'd1);
        chk("e3_pc_new", pc_new3, 32'h5C);
        chk("e3_busy_end", {31'b0, busy3}, 32'd0);
        chk("e3_pc_new1_hold", pc_new1, 32'h7A);

        // pc_in = 0 wraps EPC
        pc_in = 32'h0; exc_req1 = 3'b001;
        step();
        chk("e4_epc_wrap", epc_out1, 32'hFFFFFFFC);
        chk("e4_addr", mem_addr1, 32'd253);
        exc_req1 = 3'b000;
        step(); step();
        chk("e4_pc_load", {31'b0, pc_load1}, 32'd1);
        step();

        // reset while in VEC aborts the sequence
        addr_sel = 1'b1; exc_req1 = 3'b100;
        step();
        chk("e5_busy", {31'b0, busy1}, 32'd1);
        chk("e5_cause", {30'b0, cause1}, 32'd2);
        reset = 1'b0; exc_req1 = 3'b000;
        step();
        chk("e5_rst_busy", {31'b0, busy1}, 32'd0);
        chk("e5_rst_pcl", {31'b0, pc_load1}, 32'd0);
        chk("e5_rst_cause", {30'b0, cause1}, 32'd0);
        chk("e5_rst_addr", mem_addr1, 32'h1234);
        reset = 1'b1;
        step();
        chk("e5_no_late_pcl", {31'b0, pc_load1}, 32'd0);
        chk("e5_no_late_busy", {31'b0, busy1}, 32'd0);

        // held level re-triggers on the cycle after pc_load
        addr_sel = 1'b0; pc_in = 32'h300; exc_req1 = 3'b001;
        step(); step(); step();
        chk("e6_pc_load", {31'b0, pc_load1}, 32'd1);
        chk("e6_busy_gap", {31'b0, busy1}, 32'd0);
        step();
        chk("e6_retrig_epc", {31'b0, epc_load1}, 32'd1);
        chk("e6_retrig_busy", {31'b0, busy1}, 32'd1);
        exc_req1 = 3'b000;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
